// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: read-side pointer/empty logic of an async FIFO with a first-word-fall-through
// output stage, occupancy count and almost-empty flag, all in the read clock domain.
module fifo_rd_fwft #(
    parameter int ADDR_SIZE    = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rinc,
    input  logic [ADDR_SIZE:0]    rq2_wptr,
    input  logic [DATA_WIDTH-1:0] rmem_data,
    output logic [ADDR_SIZE:0]    rptr,
    output logic [ADDR_SIZE-1:0]  raddr,
    output logic                  rempty,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_SIZE:0]    rcount,
    output logic                  raempty
);
    localparam logic [ADDR_SIZE:0] AE = AEMPTY_LEVEL[ADDR_SIZE:0];

    logic [ADDR_SIZE:0]    rbin_q, rptr_q, rcount_q;
    logic [ADDR_SIZE:0]    rbin_d, rgray_d, wbin_sync, rcount_d;
    logic                  rempty_q, rvalid_q, raempty_q, rpop;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Refill the output stage whenever it is empty or being drained this cycle.
    assign rpop     = ~rempty_q & (~rvalid_q | rinc);
    assign rbin_d   = rbin_q + {{ADDR_SIZE{1'b0}}, rpop};
    assign rgray_d  = rbin_d ^ (rbin_d >> 1);
    assign rcount_d = wbin_sync - rbin_d;

    always_comb begin
        wbin_sync = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) wbin_sync[i] = ^(rq2_wptr >> i);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rempty_q  <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rcount_q  <= '0;
            raempty_q <= 1'b1;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rgray_d;
            rempty_q  <= rgray_d == rq2_wptr;
            rcount_q  <= rcount_d;
            raempty_q <= rcount_d <= AE;
            if (rpop) begin
                rdata_q  <= rmem_data;
                rvalid_q <= 1'b1;
            end else if (rinc) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign rptr    = rptr_q;
    assign raddr   = rbin_q[ADDR_SIZE-1:0];
    assign rempty  = rempty_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rcount  = rcount_q;
    assign raempty = raempty_q;
endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft: directed checks of the FWFT read controller against a bench-side
// memory and write pointer (ADDR_SIZE=3, DATA_WIDTH=8, AEMPTY_LEVEL=1).
module tb_fifo_rd_fwft;
    logic       rclk = 0;
    logic       rrst_n;
    logic       rinc;
    logic [3:0] rq2_wptr;
    logic [7:0] rmem_data;
    logic [3:0] rptr;
    logic [2:0] raddr;
    logic       rempty, rvalid, raempty;
    logic [7:0] rdata;
    logic [3:0] rcount;

    logic [7:0] mem [8];
    logic [3:0] wbin, rbin_e, prev;
    int checks = 0;
    int errors = 0;

    fifo_rd_fwft dut (
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_wptr(rq2_wptr),
        .rmem_data(rmem_data), .rptr(rptr), .raddr(raddr), .rempty(rempty),
        .rvalid(rvalid), .rdata(rdata), .rcount(rcount), .raempty(raempty)
    );

    always #5 rclk = ~rclk;
    assign rmem_data = mem[raddr];

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wbin[2:0]] = d;
        wbin = wbin + 4'd1;
        rq2_wptr = gray(wbin);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rptr"}, rptr, 0);
        chk({tag, "_raddr"}, raddr, 0);
        chk({tag, "_rempty"}, rempty, 1);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rcount"}, rcount, 0);
        chk({tag, "_raempty"}, raempty, 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        rrst_n = 0; rinc = 0; wbin = 0; rq2_wptr = 0;
        tick(); tick();
        rrst_n = 1;
        chk_reset("rst");

        // Single word: wptr 0 -> 1 after edge k
        mem[0] = 8'hA5; wbin = 1; rq2_wptr = gray(wbin);
        tick();
        chk("sw_k1_rempty", rempty, 0);
        chk("sw_k1_rvalid", rvalid, 0);
        chk("sw_k1_rcount", rcount, 1);
        tick();
        chk("sw_k2_rvalid", rvalid, 1);
        chk("sw_k2_rdata", rdata, 8'hA5);
        chk("sw_k2_rempty", rempty, 1);
        chk("sw_k2_rptr", rptr, 4'b0001);
        chk("sw_k2_rcount", rcount, 0);
        tick(); tick();
        chk("sw_hold_rvalid", rvalid, 1);
        chk("sw_hold_rdata", rdata, 8'hA5);
        rinc = 1;
        tick();
        rinc = 0;
        chk("sw_cons_rvalid", rvalid, 0);
        chk("sw_cons_rptr", rptr, 4'b0001);

        // Ignored reads while empty
        rinc = 1;
        for (int i = 0; i < 5; i++) tick();
        rinc = 0;
        chk("ign_rptr", rptr, 4'b0001);
        chk("ign_raddr", raddr, 1);
        chk("ign_rcount", rcount, 0);
        chk("ign_rvalid", rvalid, 0);

        // Stream four words so rptr reaches binary 5 with the stage full, then reset mid-cycle
        for (int i = 1; i <= 4; i++) push(8'hB0 + 8'(i));
        rinc = 1;
        for (int i = 0; i < 5; i++) tick();
        rinc = 0;
        chk("pre_rst_rptr", rptr, 4'b0111);
        chk("pre_rst_rvalid", rvalid, 1);
        chk("pre_rst_rdata", rdata, 8'hB4);
        chk("pre_rst_rempty", rempty, 1);
        #2;
        rrst_n = 0; wbin = 0; rq2_wptr = 0;
        #1;
        chk_reset("async_rst");
        tick();
        rrst_n = 1;
        tick();
        chk("post_rst_rempty", rempty, 1);
        chk("post_rst_rvalid", rvalid, 0);
        chk("post_rst_rptr", rptr, 0);

        // Full drain of 8 words with rinc held high
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        chk("fd_wptr_gray8", rq2_wptr, 4'b1100);
        rinc = 1;
        tick();
        chk("fd_pre_rempty", rempty, 0);
        chk("fd_pre_rcount", rcount, 8);
        chk("fd_pre_raempty", raempty, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("fd%0d_rvalid", i), rvalid, 1);
            chk($sformatf("fd%0d_rdata", i), rdata, 8'h10 + 8'(i));
            chk($sformatf("fd%0d_rcount", i), rcount, 16'(7 - i));
            chk($sformatf("fd%0d_raempty", i), raempty, 16'(7 - i <= 1));
            chk($sformatf("fd%0d_rempty", i), rempty, 16'(i == 7));
        end
        tick();
        rinc = 0;
        chk("fd_end_rvalid", rvalid, 0);
        chk("fd_end_rempty", rempty, 1);
        chk("fd_end_rptr", rptr, 4'b1100);

        // Wrap: one word at a time through binary 15 -> 0
        rbin_e = 4'd8;
        for (int i = 0; i < 20; i++) begin
            prev = rptr;
            push(8'h80 + 8'(i));
            tick();
            chk($sformatf("wr%0d_rempty_lo", i), rempty, 0);
            tick();
            rbin_e = rbin_e + 4'd1;
            chk($sformatf("wr%0d_rvalid", i), rvalid, 1);
            chk($sformatf("wr%0d_rdata", i), rdata, 8'h80 + 8'(i));
            chk($sformatf("wr%0d_rptr", i), rptr, gray(rbin_e));
            chk($sformatf("wr%0d_onebit", i), $countones(rptr ^ prev), 1);
            chk($sformatf("wr%0d_rempty_hi", i), rempty, 1);
            rinc = 1;
            tick();
            rinc = 0;
            chk($sformatf("wr%0d_drained", i), rvalid, 0);
        end

        // Concurrent advance: write pointer moves every cycle while streaming
        for (int j = 1; j <= 10; j++) begin
            push(8'h60 + 8'(j));
            rinc = 1;
            tick();
            chk($sformatf("ca%0d_rempty", j), rempty, 0);
            chk($sformatf("ca%0d_rcount", j), rcount, 1);
            if (j == 1) chk("ca1_rvalid", rvalid, 0);
            else begin
                chk($sformatf("ca%0d_rvalid", j), rvalid, 1);
                chk($sformatf("ca%0d_rdata", j), rdata, 8'h60 + 8'(j - 1));
                chk($sformatf("ca%0d_rptr", j), rptr, gray(4'd12 + 4'(j - 1)));
            end
        end
        tick();
        chk("ca_last_rdata", rdata, 8'h6A);
        chk("ca_last_rempty", rempty, 1);
        chk("ca_last_rcount", rcount, 0);
        chk("ca_last_rptr", rptr, gray(4'd6));
        tick();
        rinc = 0;
        chk("ca_end_rvalid", rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
